// File: rtl/memory_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : memory_pkg                                                    |
// | Purpose  : Shared load/store size codes, LSU state type and helper       |
// |            functions for byte-enable / store-data lane formatting.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package memory_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

    typedef enum logic [0:0] {
        LSU_IDLE = 1'b0,
        LSU_WAIT = 1'b1
    } lsu_state_t;

    // Unknown size codes and accesses that would straddle a word are refused.
    function automatic logic lsu_illegal(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: lsu_illegal = 1'b0;
            LDST_H, LDST_HU: lsu_illegal = off[0];
            LDST_W:          lsu_illegal = (off != 2'b00);
            default:         lsu_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: lsu_byte_en = 4'b0001 << off;
            LDST_H, LDST_HU: lsu_byte_en = 4'b0011 << off;
            default:         lsu_byte_en = 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across all lanes so the enabled lane is correct
    // regardless of offset.
    function automatic logic [31:0] lsu_store_data(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            LDST_B, LDST_BU: lsu_store_data = {4{wd[7:0]}};
            LDST_H, LDST_HU: lsu_store_data = {2{wd[15:0]}};
            default:         lsu_store_data = wd;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_extract.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lsu_load_extract                                              |
// | Purpose  : Selects the addressed byte/half of a memory word and sign- or |
// |            zero-extends it according to the load size.                  |
// | Ports    : i_word  memory read word                                      |
// |            i_size  load size code                                        |
// |            i_off   byte offset within the word                           |
// |            o_data  extended 32-bit load result                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module lsu_load_extract
    import memory_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'(i_word >> {i_off, 3'b000});
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_data = {24'd0, w_byte};
            LDST_H:  o_data = {{16{w_half[15]}}, w_half};
            LDST_HU: o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : riscv_lsu                                                     |
// | Purpose  : Load/store unit: turns core byte/half/word requests into      |
// |            word-addressed memory transactions, extends load data, stalls |
// |            the core until the response and flags misaligned/illegal      |
// |            accesses and response timeouts.                               |
// | Ports    : clk_i, rst_ni (async, active-low)                             |
// |            core_*  request from / response to the core                   |
// |            misaligned_o, bus_err_o  one-cycle error pulses               |
// |            mem_*   synchronous-read data memory interface                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module riscv_lsu
    import memory_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam bit          c_timeout_en   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_state_next;
    logic        r_we;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic [31:2] r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_cnt;

    logic [1:0]  w_off;
    logic        w_illegal;
    logic        w_timeout;
    logic [31:0] w_load_data;

    assign w_off     = core_addr_i[1:0];
    assign w_illegal = lsu_illegal(core_size_i, w_off);
    assign w_timeout = c_timeout_en && (r_cnt == c_timeout_last);

    lsu_load_extract u_extract (
        .i_word (mem_rd_i),
        .i_size (r_size),
        .i_off  (r_off),
        .o_data (w_load_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= LSU_IDLE;
            r_we    <= 1'b0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_addr  <= 30'd0;
            r_wd    <= 32'd0;
            r_cnt   <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == LSU_IDLE) begin
                if (core_req_i && !w_illegal) begin
                    r_we   <= core_we_i;
                    r_size <= core_size_i;
                    r_off  <= w_off;
                    r_addr <= core_addr_i[31:2];
                    r_wd   <= core_wd_i;
                end
            end else if (w_state_next == LSU_IDLE) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_addr_o   = 32'd0;
        mem_wd_o     = 32'd0;
        core_stall_o = 1'b0;
        core_rd_o    = 32'd0;
        misaligned_o = 1'b0;
        bus_err_o    = 1'b0;

        case (r_state)
            LSU_IDLE: begin
                if (core_req_i) begin
                    if (w_illegal) begin
                        misaligned_o = 1'b1;
                    end else begin
                        // Issue straight from the core inputs so the synchronous
                        // memory can answer in the very next cycle.
                        mem_req_o    = 1'b1;
                        mem_we_o     = core_we_i;
                        mem_be_o     = lsu_byte_en(core_size_i, w_off);
                        mem_addr_o   = {core_addr_i[31:2], 2'b00};
                        mem_wd_o     = lsu_store_data(core_size_i, core_wd_i);
                        core_stall_o = 1'b1;
                        w_state_next = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                mem_req_o  = 1'b1;
                mem_we_o   = r_we;
                mem_be_o   = lsu_byte_en(r_size, r_off);
                mem_addr_o = {r_addr, 2'b00};
                mem_wd_o   = lsu_store_data(r_size, r_wd);
                if (mem_ready_i) begin
                    core_rd_o    = w_load_data;
                    w_state_next = LSU_IDLE;
                end else if (w_timeout) begin
                    bus_err_o    = 1'b1;
                    w_state_next = LSU_IDLE;
                end else begin
                    core_stall_o = 1'b1;
                end
            end
            default: w_state_next = LSU_IDLE;
        endcase

        // Reset must silence the bus at once even while the core still holds a
        // request on its inputs.
        if (!rst_ni) begin
            w_state_next = LSU_IDLE;
            mem_req_o    = 1'b0;
            mem_we_o     = 1'b0;
            mem_be_o     = 4'b0000;
            mem_addr_o   = 32'd0;
            mem_wd_o     = 32'd0;
            core_stall_o = 1'b0;
            core_rd_o    = 32'd0;
            misaligned_o = 1'b0;
            bus_err_o    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_riscv_lsu                                                  |
// | Purpose  : Self-checking bench for riscv_lsu (timeout 4 and timeout 0    |
// |            instances) against a behavioural reference model.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_riscv_lsu;
    import memory_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req = 1'b0;
    logic        d0_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'd0;
    logic [31:0] core_wd = 32'd0;
    logic [31:0] mem_rd = 32'd0;
    logic        mem_ready = 1'b0;

    logic [31:0] rd, maddr, mwd;
    logic        stall, mis, berr, mreq, mwe;
    logic [3:0]  mbe;
    logic [31:0] d0_rd, d0_maddr, d0_mwd;
    logic        d0_stall, d0_mis, d0_berr, d0_mreq, d0_mwe;
    logic [3:0]  d0_mbe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .core_req_i(core_req), .core_we_i(core_we),
        .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
        .core_rd_o(rd), .core_stall_o(stall), .misaligned_o(mis), .bus_err_o(berr),
        .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe), .mem_addr_o(maddr),
        .mem_wd_o(mwd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
    );

    riscv_lsu #(.TIMEOUT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .core_req_i(d0_req), .core_we_i(core_we),
        .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
        .core_rd_o(d0_rd), .core_stall_o(d0_stall), .misaligned_o(d0_mis), .bus_err_o(d0_berr),
        .mem_req_o(d0_mreq), .mem_we_o(d0_mwe), .mem_be_o(d0_mbe), .mem_addr_o(d0_maddr),
        .mem_wd_o(d0_mwd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input logic [2:0] s, input logic [1:0] off);
        if (s == 3 || s == 6 || s == 7) return 1'b0;
        if ((s == 1 || s == 5) && (off % 2 != 0)) return 1'b0;
        if (s == 2 && off != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] s, input logic [1:0] off);
        if (s == 2) return 32'd15;
        if (s == 1 || s == 5) return 32'd3 << off;
        return 32'd1 << off;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] wd);
        if (s == 0 || s == 4) return {24'd0, wd[7:0]} * 32'h01010101;
        if (s == 1 || s == 5) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] s, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (s)
            3'd0:    return 32'($signed(sh[7:0]));
            3'd4:    return {24'd0, sh[7:0]};
            3'd1:    return 32'($signed(sh[15:0]));
            3'd5:    return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after release
    // (or one cycle later again when gap is set, after checking the idle cycle).
    task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input int lat, input logic [31:0] rdata,
                             input bit gap, input string tag);
        logic [1:0] off;
        bit done;
        off  = addr[1:0];
        done = 1'b0;
        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
        mem_ready = 1'b0; mem_rd = $urandom;
        @(negedge clk);
        if (!m_legal(size, off)) begin
            check({tag, " mis"}, mis, 1);
            check({tag, " mis req"}, mreq, 0);
            check({tag, " mis stall"}, stall, 0);
            check({tag, " mis berr"}, berr, 0);
        end else begin
            check({tag, " req"}, mreq, 1);
            check({tag, " stall0"}, stall, 1);
            check({tag, " we"}, mwe, we);
            check({tag, " be"}, mbe, m_be(size, off));
            check({tag, " addr"}, maddr, addr & 32'hFFFF_FFFC);
            if (we) check({tag, " wd"}, mwd, m_wd(size, wd));
            check({tag, " mis0"}, mis, 0);
            check({tag, " rd0"}, rd, 0);
            for (int c = 1; c <= TO + 4 && !done; c++) begin
                @(posedge clk); #1;
                core_addr = $urandom; core_wd = $urandom;
                core_size = 3'($urandom); core_we = 1'($urandom);
                mem_ready = (c == lat);
                mem_rd    = (c == lat) ? rdata : $urandom;
                @(negedge clk);
                check({tag, " w req"}, mreq, 1);
                check({tag, " w we"}, mwe, we);
                check({tag, " w be"}, mbe, m_be(size, off));
                check({tag, " w addr"}, maddr, addr & 32'hFFFF_FFFC);
                if (we) check({tag, " w wd"}, mwd, m_wd(size, wd));
                check({tag, " w mis"}, mis, 0);
                if (c == lat) begin
                    check({tag, " rel stall"}, stall, 0);
                    check({tag, " rel berr"}, berr, 0);
                    if (!we) check({tag, " rd"}, rd, m_load(size, off, rdata));
                    done = 1'b1;
                end else if (c == TO) begin
                    check({tag, " to berr"}, berr, 1);
                    check({tag, " to stall"}, stall, 0);
                    check({tag, " to rd"}, rd, 0);
                    done = 1'b1;
                end else begin
                    check({tag, " w stall"}, stall, 1);
                    check({tag, " w rd"}, rd, 0);
                    check({tag, " w berr"}, berr, 0);
                end
            end
        end
        @(posedge clk); #1;
        core_req = 1'b0; mem_ready = 1'b0; mem_rd = $urandom;
        if (gap) begin
            @(negedge clk);
            check({tag, " idle req"}, mreq, 0);
            check({tag, " idle stall"}, stall, 0);
            check({tag, " idle rd"}, rd, 0);
            check({tag, " idle berr"}, berr, 0);
            check({tag, " idle mis"}, mis, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // reset: outputs quiet even with a legal request presented
        repeat (2) @(posedge clk);
        #1;
        core_req = 1'b1; core_size = LDST_W; core_addr = 32'h10;
        @(negedge clk);
        check("rst req", mreq, 0);
        check("rst stall", stall, 0);
        check("rst rd", rd, 0);
        check("rst mis", mis, 0);
        check("rst berr", berr, 0);
        check("rst be", mbe, 0);
        check("rst addr", maddr, 0);
        core_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_access(1'b1, LDST_W,  32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b1, "sw");
        do_access(1'b1, LDST_B,  32'h13, 32'h000000A5, 2, 32'h0, 1'b0, "sb");
        do_access(1'b0, LDST_B,  32'h22, 32'h0, 1, 32'h12805634, 1'b0, "lb");
        do_access(1'b0, LDST_BU, 32'h22, 32'h0, 1, 32'h12805634, 1'b0, "lbu");
        do_access(1'b0, LDST_HU, 32'h22, 32'h0, 1, 32'h12805634, 1'b0, "lhu");
        do_access(1'b0, LDST_H,  32'h22, 32'h0, 2, 32'h12805634, 1'b1, "lh");
        do_access(1'b0, LDST_W,  32'h06, 32'h0, 1, 32'h0, 1'b1, "lw_mis");
        do_access(1'b0, 3'd3,    32'h20, 32'h0, 1, 32'h0, 1'b1, "size3");
        do_access(1'b0, LDST_W,  32'h30, 32'h0, 100, 32'h0, 1'b1, "lw_to");

        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom), 3'($urandom), $urandom, $urandom,
                      int'($urandom_range(1, 6)), $urandom, 1'($urandom), "rnd");
        end

        // timeout disabled: stalls indefinitely, then reset mid-wait
        d0_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h40;
        core_wd = 32'h0; mem_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("inf stall", d0_stall, 1);
            check("inf berr", d0_berr, 0);
            check("inf req", d0_mreq, 1);
            check("inf rd", d0_rd, 0);
            check("inf mis", d0_mis, 0);
            check("inf we", d0_mwe, 0);
            check("inf be", d0_mbe, 4'hF);
            check("inf addr", d0_maddr, 32'h40);
            check("inf wd", d0_mwd, 32'h0);
            @(posedge clk); #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("arst d0 req", d0_mreq, 0);
        check("arst d0 stall", d0_stall, 0);
        check("arst req", mreq, 0);
        check("arst stall", stall, 0);
        d0_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_access(1'b0, LDST_W, 32'h44, 32'h0, 1, 32'hCAFEF00D, 1'b1, "lw_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
